// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store unit.
// Accepts one LW/LB/SW/SB request at a time, waits LATENCY cycles, then
// completes it with a one-cycle Ready pulse. Illegal requests (read+write
// together, misaligned word access, address beyond DEPTH_WORDS) still take
// the full latency and complete with AddrError set and memory untouched.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteMode,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Busy,
    output logic        AddrError
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
    localparam logic        LAT_ZERO = (LATENCY == 0);
    localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Byte lane selected by lane, sign-extended to a full word.
    function automatic logic [31:0] laneExtract(input logic [31:0] word, input logic [1:0] lane);
        logic signed [7:0]  laneByte;
        logic signed [31:0] extended;
        laneByte = word[{lane, 3'b000} +: 8];
        extended = laneByte;
        return extended;
    endfunction

    // Replace one little-endian byte lane of word, keeping the other three.
    function automatic logic [31:0] laneMerge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [7:0] laneByte);
        logic [31:0] merged;
        merged = word;
        merged[{lane, 3'b000} +: 8] = laneByte;
        return merged;
    endfunction

    // Load result as the core sees it: whole word or sign-extended byte.
    function automatic logic [31:0] formatRead(input logic [31:0] word, input logic [1:0] lane,
                                               input logic byteAccess);
        return byteAccess ? laneExtract(word, lane) : word;
    endfunction

    logic [31:0]      mem [DEPTH_WORDS];

    logic [1:0]       state;
    logic [3:0]       waitCnt;

    logic [IDX_W-1:0] idxQ;
    logic [1:0]       laneQ;
    logic [31:0]      wdataQ;
    logic             byteQ;
    logic             readQ;
    logic             writeQ;
    logic             errQ;

    logic             reqValid;
    logic             reqErr;

    logic [IDX_W-1:0] commitIdx;
    logic [1:0]       commitLane;
    logic [31:0]      commitData;
    logic             commitByte;
    logic             commitWrite;
    logic             enterResp;
    logic             memWe;

    // Classify the request currently on the inputs.
    always_comb begin
        reqValid = MemRead || MemWrite;
        reqErr   = (MemRead && MemWrite)
                || (!ByteMode && (Address[1:0] != 2'b00))
                || ({2'b00, Address[31:2]} >= DEPTH_L);
    end

    // Control FSM: IDLE accepts, WAIT counts down the latency, RESP completes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        if (LAT_ZERO) begin
                            state <= RESP;
                        end else begin
                            state   <= WAIT;
                            waitCnt <= LAT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (waitCnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture the accepted request; data registers carry no reset.
    always_ff @(posedge Clk) begin
        if ((state == IDLE) && reqValid) begin
            idxQ   <= Address[IDX_W+1:2];
            laneQ  <= Address[1:0];
            wdataQ <= WriteData;
            byteQ  <= ByteMode;
            readQ  <= MemRead;
            writeQ <= MemWrite;
            errQ   <= reqErr;
        end
    end

    // Store commits on the edge entering RESP; with zero latency that edge is
    // the accepting one, so the live inputs are used instead of the latches.
    always_comb begin
        commitIdx   = idxQ;
        commitLane  = laneQ;
        commitData  = wdataQ;
        commitByte  = byteQ;
        commitWrite = writeQ && !errQ;
        enterResp   = (state == WAIT) && (waitCnt == 4'd0);
        if ((state == IDLE) && LAT_ZERO) begin
            commitIdx   = Address[IDX_W+1:2];
            commitLane  = Address[1:0];
            commitData  = WriteData;
            commitByte  = ByteMode;
            commitWrite = MemWrite && !reqErr;
            enterResp   = reqValid;
        end
        memWe = enterResp && commitWrite && !Reset;
    end

    // Storage array; never reset, so contents survive a Reset pulse.
    always_ff @(posedge Clk) begin
        if (memWe) begin
            mem[commitIdx] <= commitByte ? laneMerge(mem[commitIdx], commitLane, commitData[7:0])
                                         : commitData;
        end
    end

    // Response outputs are driven only in RESP and are zero otherwise.
    always_comb begin
        Ready     = (state == RESP);
        Busy      = (state != IDLE);
        AddrError = Ready && errQ;
        ReadData  = '0;
        if (Ready && readQ && !errQ) begin
            ReadData = formatRead(mem[idxQ], laneQ, byteQ);
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder with directed cases for
// stores/loads, byte lanes, rejected requests, back-to-back requests, reset
// during a pending write, and a zero-latency instance.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0, ByteMode = 1'b0;
    logic [31:0] Address = '0, WriteData = '0;
    logic [31:0] ReadData;
    logic        Ready, Busy, AddrError;

    logic        zRead = 1'b0, zWrite = 1'b0, zByte = 1'b0;
    logic [31:0] zAddr = '0, zWdata = '0;
    logic [31:0] zRdata;
    logic        zReady, zBusy, zErr;

    always #5 Clk = ~Clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .ByteMode(ByteMode), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .Ready(Ready), .Busy(Busy), .AddrError(AddrError)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dutZ (
        .Clk(Clk), .Reset(Reset), .MemRead(zRead), .MemWrite(zWrite),
        .ByteMode(zByte), .Address(zAddr), .WriteData(zWdata),
        .ReadData(zRdata), .Ready(zReady), .Busy(zBusy), .AddrError(zErr)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        longint      t;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] memM [DEPTH];
    int          nTests = 0;
    int          nFail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic chkT(input string name, input longint act, input longint exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: Ready seen at t=%0d, expected t=%0d", name, act, exp);
        end
    endtask

    // Reference behaviour: what the request should return, and its effect on memory.
    function automatic void model(input bit rd, input bit wr, input bit bm,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] data, output logic err);
        int unsigned idx;
        int          lane;
        logic [7:0]  b;
        idx  = addr >> 2;
        lane = int'(addr % 4);
        err  = (rd && wr) || (!bm && lane != 0) || (idx >= DEPTH);
        data = 32'h0;
        if (!err) begin
            if (rd) begin
                if (bm) begin
                    b    = 8'(memM[idx] >> (8 * lane));
                    data = {{24{b[7]}}, b};
                end else begin
                    data = memM[idx];
                end
            end
            if (wr) begin
                if (bm) memM[idx][8*lane +: 8] = wd[7:0];
                else    memM[idx] = wd;
            end
        end
    endfunction

    // Drive one request from a negedge, push its expected completion, wait for idle.
    task automatic issue(input bit rd, input bit wr, input bit bm,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit useExp, input logic [31:0] expData, input bit expErr,
                         input string name);
        exp_t        e;
        logic [31:0] md;
        logic        me;
        int          n;
        MemRead = rd; MemWrite = wr; ByteMode = bm; Address = addr; WriteData = wd;
        @(posedge Clk);
        model(rd, wr, bm, addr, wd, md, me);
        e.data = useExp ? expData : md;
        e.err  = useExp ? expErr : me;
        e.t    = $time + LAT * 10 + 5;
        e.name = name;
        sb.push_back(e);
        @(negedge Clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        n = 0;
        while (Busy && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 40) begin
            nTests++; nFail++;
            $display("FAIL %s_idle: Busy still %0b after %0d cycles, expected 0", name, Busy, n);
        end
    endtask

    // Zero-latency instance: completion must be visible in the cycle after acceptance.
    task automatic zOp(input bit rd, input bit wr, input bit bm,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] expData, input bit expErr, input string name);
        zRead = rd; zWrite = wr; zByte = bm; zAddr = addr; zWdata = wd;
        @(posedge Clk);
        @(negedge Clk);
        chk({name, "_ready"}, {31'b0, zReady}, 32'd1);
        chk({name, "_busy"},  {31'b0, zBusy},  32'd1);
        chk({name, "_data"},  zRdata, expData);
        chk({name, "_err"},   {31'b0, zErr},   {31'b0, expErr});
        zRead = 1'b0; zWrite = 1'b0;
        @(negedge Clk);
        chk({name, "_ready_after"}, {31'b0, zReady}, 32'd0);
        chk({name, "_busy_after"},  {31'b0, zBusy},  32'd0);
    endtask

    // Monitor: every Ready pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (Ready) begin
            if (sb.size() == 0) begin
                nTests++; nFail++;
                $display("FAIL unexpected_ready: Ready=1 at t=%0d, expected no response pending", $time);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_data"}, ReadData, e.data);
                chk({e.name, "_err"}, {31'b0, AddrError}, {31'b0, e.err});
                chkT({e.name, "_time"}, $time, e.t);
            end
        end else begin
            chk("idle_rdata", ReadData, 32'h0);
            chk("idle_err", {31'b0, AddrError}, 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, wd, md;
        logic        me;
        bit          rd, wr, bm;
        int          r, op;
        exp_t        e;

        for (int i = 0; i < DEPTH; i++) memM[i] = 32'h0;

        // Reset state
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_ready", {31'b0, Ready}, 32'h0);
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        chk("rst_err", {31'b0, AddrError}, 32'h0);
        chk("rst_rdata", ReadData, 32'h0);
        Reset = 1'b0;

        // Preload words 0..15, starting on the first edge after reset release
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            issue(1'b0, 1'b1, 1'b0, 32'(w * 4), wd, 1'b0, 32'h0, 1'b0, "preload");
        end

        // Word store then load
        issue(0, 1, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, "sw_10");
        issue(1, 0, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, "lw_10");

        // Byte lanes and sign extension
        issue(0, 1, 0, 32'h20, 32'h11223344, 1, 32'h0, 0, "sw_20");
        issue(0, 1, 1, 32'h22, 32'hFFFFFF80, 1, 32'h0, 0, "sb_22");
        issue(1, 0, 0, 32'h20, 32'h0, 1, 32'h11803344, 0, "lw_20");
        issue(1, 0, 1, 32'h22, 32'h0, 1, 32'hFFFFFF80, 0, "lb_22");
        issue(1, 0, 1, 32'h20, 32'h0, 1, 32'h00000044, 0, "lb_20");

        // Rejected requests
        issue(1, 0, 0, 32'h13, 32'h0, 1, 32'h0, 1, "lw_misaligned");
        issue(1, 1, 0, 32'h10, 32'h0BADF00D, 1, 32'h0, 1, "rd_and_wr");
        issue(1, 0, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, "lw_10_unchanged");
        issue(1, 0, 0, 32'h400, 32'h0, 1, 32'h0, 1, "lw_out_of_range");

        // Randomised mix against the reference model
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 99);
            op = $urandom_range(0, 3);
            rd = (op < 2);
            wr = (op >= 2);
            bm = (op == 1) || (op == 3);
            a  = 32'($urandom_range(0, 63));
            if (!bm && r >= 10) a[1:0] = 2'b00;
            if (r >= 10 && r < 15) a = 32'($urandom_range(256, 4000)) << 2;
            if (r >= 15 && r < 18) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            wd = $urandom;
            issue(rd, wr, bm, a, wd, 1'b0, 32'h0, 1'b0, "rand");
        end

        // Request held high: re-accepted every LAT+2 cycles
        MemRead = 1'b1; MemWrite = 1'b0; ByteMode = 1'b0; Address = 32'h24;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk);
            if (i < 10 && (i % (LAT + 2)) == 0) begin
                model(1'b1, 1'b0, 1'b0, 32'h24, 32'h0, md, me);
                e.data = md; e.err = me; e.t = $time + LAT * 10 + 5; e.name = "hold";
                sb.push_back(e);
            end
            @(negedge Clk);
            chk($sformatf("hold_busy%0d", i), {31'b0, Busy},
                {31'b0, 1'((i % (LAT + 2)) != (LAT + 1))});
            if (i == 9) MemRead = 1'b0;
        end

        // Reset while a store is waiting: store discarded, no Ready
        MemWrite = 1'b1; ByteMode = 1'b0; Address = 32'h8; WriteData = 32'h12345678;
        @(posedge Clk);
        @(negedge Clk);
        MemWrite = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk("midrst_ready", {31'b0, Ready}, 32'h0);
        chk("midrst_busy", {31'b0, Busy}, 32'h0);
        chk("midrst_err", {31'b0, AddrError}, 32'h0);
        chk("midrst_rdata", ReadData, 32'h0);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        issue(1, 0, 0, 32'h8, 32'h0, 0, 32'h0, 0, "lw_8_after_reset");

        repeat (4) @(negedge Clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        // Zero-latency instance
        zOp(0, 1, 0, 32'h30, 32'hA5A50F0F, 32'h0, 0, "z_sw");
        zOp(1, 0, 0, 32'h30, 32'h0, 32'hA5A50F0F, 0, "z_lw");
        zOp(1, 0, 1, 32'h33, 32'h0, 32'hFFFFFFA5, 0, "z_lb3");
        zOp(1, 0, 1, 32'h31, 32'h0, 32'h0000000F, 0, "z_lb1");
        zOp(1, 0, 0, 32'h31, 32'h0, 32'h0, 1, "z_misaligned");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles inserted before each response; legal range 0..15.
REQ-003 SHALL have port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port MemRead, input, 1: read request from the core (LW/LB).
REQ-006 SHALL have port MemWrite, input, 1: write request from the core (SW/SB).
REQ-007 SHALL have port ByteMode, input, 1: 1 = byte access (LB/SB), 0 = word access.
REQ-008 SHALL have port Address, input, 32: byte address, i.e. the core's ALU output.
REQ-009 SHALL have port WriteData, input, 32: store data; in byte mode only bits 7:0 are used.
REQ-010 SHALL have port ReadData, output, 32: load result, valid only while Ready=1.
REQ-011 SHALL have port Ready, output, 1: one-cycle pulse that completes a request.
REQ-012 SHALL have port Busy, output, 1: high while a request is accepted but not yet completed.
REQ-013 SHALL have port AddrError, output, 1: qualifies Ready; high means the request was rejected.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 IDLE SHALL sample a request at a rising edge when MemRead or MemWrite is 1.
REQ-016 On acceptance, the block SHALL latch Address, WriteData, ByteMode and the operation.
REQ-017 Inputs SHALL be ignored outside IDLE.
REQ-018 Accepted request, LATENCY>0: the FSM SHALL go IDLE->WAIT and load a down-counter with LATENCY-1.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP at the edge where the counter is 0.
REQ-020 Accepted request, LATENCY=0: the FSM SHALL go IDLE->RESP directly.
REQ-021 Ready SHALL be high for exactly the cycle(s) the FSM is in RESP, giving Ready LATENCY+1 cycles after the accepting edge.
REQ-022 RESP SHALL always return to IDLE on the next edge.
REQ-023 A request still held high after RESP SHALL be re-accepted as a new request at the following IDLE edge.
REQ-024 Busy SHALL be 1 in WAIT and in RESP, and 0 in IDLE.
REQ-025 The request SHALL be rejected if any of these holds:
  - MemRead and MemWrite are both 1;
  - word access with Address[1:0] != 0;
  - Address[31:2] >= DEPTH_WORDS.
REQ-026 A rejected request SHALL still traverse WAIT with the full latency.
REQ-027 A rejected request SHALL complete with AddrError=1, ReadData=0, and memory unmodified.
REQ-028 A word write SHALL store all 32 bits at index Address[31:2] on the edge entering RESP.
REQ-029 A byte write SHALL modify only lane Address[1:0], little-endian (lane 0 = bits 7:0).
REQ-030 A byte write SHALL leave the other three lanes unchanged.
REQ-031 A word read SHALL present the stored word on ReadData during RESP.
REQ-032 A byte read SHALL present the addressed lane sign-extended to 32 bits.
REQ-033 A read SHALL reflect all writes completed before it was accepted.
REQ-034 During a write's RESP cycle, ReadData SHALL be 0 and AddrError SHALL be 0.
REQ-035 Outside RESP, ReadData SHALL be 0 and AddrError SHALL be 0.

Reset
REQ-036 While Reset=1, the block SHALL force state IDLE, counter 0, Ready=0, Busy=0, AddrError=0 and ReadData=0, independent of Clk.
REQ-037 Reset SHALL NOT clear memory contents.
REQ-038 Reset asserted in WAIT SHALL discard the pending write, leaving the target word unchanged.
REQ-039 No Ready pulse SHALL follow a reset-aborted request.
REQ-040 The first edge after Reset deasserts SHALL be able to accept a request.

Verification
REQ-041 Bench SHALL cover a word store then load: SW 0xDEADBEEF @0x10, then LW @0x10 -> Ready exactly 3 cycles after each accept (LATENCY=2), ReadData=0xDEADBEEF, AddrError=0.
REQ-042 Bench SHALL cover byte-lane stores and sign extension:
  - Preload word 0x11223344 @0x20.
  - SB 0x80 @0x22 -> word reads 0x11803344.
  - LB @0x22 -> 0xFFFFFF80.
  - LB @0x20 -> 0x00000044.
REQ-043 Bench SHALL cover rejected requests:
  - LW @0x13 (misaligned) -> Ready with AddrError=1 and ReadData=0.
  - MemRead=MemWrite=1 -> AddrError=1 and memory unchanged.
  - LW @0x400 with DEPTH_WORDS=256 -> AddrError=1.
REQ-044 Bench SHALL cover back-to-back requests: MemRead held high for 10 cycles -> Ready pulses one cycle wide, 4 cycles apart; Busy low exactly one cycle between transactions.
REQ-045 Bench SHALL cover reset mid-operation: Reset pulsed in WAIT of SW 0x12345678 @0x8 -> outputs 0 at once, no Ready, subsequent LW @0x8 returns the prior value.
REQ-046 Bench SHALL cover LATENCY=0: LW accepted at edge N -> Ready=1 in the cycle after edge N, Busy=1 for exactly that cycle.
